regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side front end for the CPU register file: merges the fixed-latency pipeline writeback stream and the variable-latency multicycle-unit result stream into the single register-file write port (`wr`/`addr3`/`data3`). The pipeline has strict priority. Multicycle results are buffered in a small in-order FIFO and drained in cycles the pipeline leaves idle. Writes to register 0 are filtered here, so the register file never sees them.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries for multicycle results; power of 2, ≥ 2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p_wr`  in  1  pipeline writeback request; no backpressure.
- `p_addr`  in  AW  pipeline destination register.
- `p_data`  in  DW  pipeline result.
- `m_valid`  in  1  multicycle result valid.
- `m_ready`  out  1  multicycle result accepted on a cycle where `m_valid && m_ready`.
- `m_addr`  in  AW  multicycle destination register.
- `m_data`  in  DW  multicycle result.
- `p_stall`  out  1  registered; requests a pipeline writeback bubble.
- `q_count`  out  $clog2(DEPTH)+1  number of valid FIFO entries.
- `wr`  out  1  register-file write enable (registered).
- `addr3`  out  AW  register-file write address (registered).
- `data3`  out  DW  register-file write data (registered).
- `pending`  out  2**AW  per-register queued-write flags; present only with `REGFILE_WB_PENDING_EN`.

## Operation
- Reset values (`reset` low): `wr`=0, `addr3`=0, `data3`=0, `q_count`=0, `p_stall`=0, `m_ready`=0, FIFO pointers=0, `pending`=0. Asserting reset mid-operation discards all queued entries.
- After reset: `m_ready` = (`q_count` != `DEPTH`).
- Handshake filter: a handshake with `m_addr`=0 completes normally but is not enqueued.
- Pipeline filter: `p_wr` with `p_addr`=0 is ignored and does not consume the output slot.
- Output selection, evaluated every cycle:
  - If `p_wr` and `p_addr`≠0: the output register loads `wr`=1 with `p_addr`/`p_data`.
  - Else if FIFO non-empty: pop the head and load `wr`=1 with its address and data.
  - Else: `wr`=0. `addr3`/`data3` hold their previous values.
- FIFO ordering: strictly in order. A push and a pop in the same cycle are both performed, and `q_count` is unchanged.
- Push into an empty FIFO: the entry is not bypassed and is popped no earlier than the following cycle.
- `p_stall`: registered, =1 in the cycle after `q_count` reaches `DEPTH`, and stays 1 while the FIFO is full.
  - While `p_stall`=1 the pipeline must not assert `p_wr`.
  - If it does, the pipeline write still wins. Simulation flags this with an `$error`.
- Cross-source ordering: same-register write ordering between the two sources is the issuer's responsibility. Use `pending` to detect conflicts.
- No arithmetic on data; `data3` is bit-exact with the source data.

## Timing
- Pipeline latency: `p_wr` sampled at edge N → `wr`=1 visible after edge N (one register stage).
- Multicycle latency, idle pipeline: handshake at edge N → entry written → `wr`=1 after edge N+1. Minimum 2 cycles.
- Throughput: one register-file write per cycle.
- FIFO drain rate: one entry per cycle without `p_wr`.
- Full boundary: `m_ready` drops combinationally from `q_count`. When a pop occurs in the same cycle, `m_ready` is not raised early (registered count only).

## Configuration
- `REGFILE_WB_PENDING_EN` defined: the `pending` port exists.
  - Bit i = 1 iff at least one valid FIFO entry targets register i.
  - Decoded combinationally from FIFO storage and valid bits.
  - Used by the hazard unit to stall reads of register i.
- Not defined: the `pending` port and its decode logic are absent. All other behaviour is identical.

## Structure
- Shared package `regfile_pkg`: `REG_AW`=5, `REG_DW`=32, `NUM_REGS`=32, `REG_ZERO`=5'd0, and typedef `wb_req_t` {addr, data}. Shared with the register file and the hazard unit.
- Sub-module `wb_fifo`: parameterised synchronous FIFO.
  - Async active-low reset.
  - Ports: push, pop, full, empty, count, head data.
  - Exposes per-entry valid and address for the `pending` decode.
- Top level contains only the priority mux, the zero filter, the output register and `p_stall`.

## Test plan
- Reset then idle: `reset` low at t=0 and released at 13 ns → all outputs 0; `m_ready`=1 after release; `wr` stays 0 with no requests.
- Pipeline write: `p_wr`=1, `p_addr`=1, `p_data`=32'h00ff00ff at edge N → `wr`=1, `addr3`=1, `data3`=32'h00ff00ff after edge N; `wr`=0 the next cycle.
- Queued drain: pipeline idle; handshake `m_addr`=2, `m_data`=32'haa55aa55 at edge N → `wr`=1, `addr3`=2 after edge N+1; `q_count` returns to 0.
- Priority and fill:
  - Stimulus: continuous `p_wr` to reg 3 while pushing 4 results to regs 4–7.
  - Required: `q_count`=4, `m_ready`=0, `p_stall`=1.
  - Then drop `p_wr`: writes to 4, 5, 6, 7 occur in order on consecutive cycles.
- Zero filtering: `p_wr` with `p_addr`=0, then handshake with `m_addr`=0 → `wr` never asserts; `q_count` stays 0; handshake still completes.
- Reset mid-queue: 3 entries queued, `reset` pulsed low → `q_count`=0 and `wr`=0 immediately (asynchronous); no stale write after release. With the macro defined, `pending` is 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions: address/data widths, register count,
// the hard-wired zero register and the writeback request bundle.
package regfile_pkg;

   localparam int REG_AW   = 5;
   localparam int REG_DW   = 32;
   localparam int NUM_REGS = 32;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: in-order synchronous FIFO holding multicycle writeback results.
// Ports: clk, rst_n (async active-low), push/push_addr/push_data,
//   pop, full, empty, count, head_addr/head_data, and (with
//   REGFILE_WB_PENDING_EN) per-entry valid ent_vld and address ent_addr.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data
`ifdef REGFILE_WB_PENDING_EN
   ,
   output logic [DEPTH-1:0]    ent_vld,
   output logic [DEPTH*AW-1:0] ent_addr
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
         end
      end
   end

   assign count     = cnt_q;
   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

`ifdef REGFILE_WB_PENDING_EN
   logic [DEPTH-1:0] vld_q, vld_d;

   // Push and pop never hit the same slot: push needs !full, pop !empty.
   always_comb begin
      vld_d = vld_q;
      if (do_push) vld_d[wr_ptr_q] = 1'b1;
      if (do_pop)  vld_d[rd_ptr_q] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   assign ent_vld = vld_q;

   always_comb begin
      ent_addr = '0;
      for (int i = 0; i < DEPTH; i++)
         ent_addr[i*AW +: AW] = addr_q[i];
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write arbiter: pipeline writeback has priority, multicycle
// results queue in wb_fifo and drain in idle slots; writes to x0 are dropped.
// Ports: clk, reset (async active-low), p_wr/p_addr/p_data, m_valid/m_ready/
//   m_addr/m_data, p_stall, q_count, wr/addr3/data3, and pending when
//   REGFILE_WB_PENDING_EN is defined.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_wr,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_data,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_data,
   output logic          p_stall,
   output logic [CW-1:0] q_count,
   output logic          wr,
   output logic [AW-1:0] addr3,
   output logic [DW-1:0] data3
`ifdef REGFILE_WB_PENDING_EN
   ,
   output logic [2**AW-1:0] pending
`endif
);

   logic          p_take, m_push, f_pop;
   logic          f_full, f_empty;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;

   logic          wr_q, wr_d;
   logic [AW-1:0] addr3_q, addr3_d;
   logic [DW-1:0] data3_q, data3_d;
   logic          p_stall_q;

   // Register 0 is hard-wired, so writes to it are discarded here.
   assign p_take  = p_wr && (p_addr != '0);
   // Held low during reset; afterwards purely from the registered count.
   assign m_ready = reset && !f_full;
   // Zero-target handshakes complete but are never stored.
   assign m_push  = m_valid && m_ready && (m_addr != '0);
   assign f_pop   = !p_take && !f_empty;

`ifdef REGFILE_WB_PENDING_EN
   logic [DEPTH-1:0]    ent_vld;
   logic [DEPTH*AW-1:0] ent_addr;
`endif

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (m_push),
      .push_addr (m_addr),
      .push_data (m_data),
      .pop       (f_pop),
      .full      (f_full),
      .empty     (f_empty),
      .count     (q_count),
      .head_addr (head_addr),
      .head_data (head_data)
`ifdef REGFILE_WB_PENDING_EN
      ,
      .ent_vld   (ent_vld),
      .ent_addr  (ent_addr)
`endif
   );

   always_comb begin
      wr_d    = 1'b0;
      addr3_d = addr3_q;
      data3_d = data3_q;
      unique case (1'b1)
         p_take: begin
            wr_d    = 1'b1;
            addr3_d = p_addr;
            data3_d = p_data;
         end
         f_pop: begin
            wr_d    = 1'b1;
            addr3_d = head_addr;
            data3_d = head_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q      <= 1'b0;
         addr3_q   <= '0;
         data3_q   <= '0;
         p_stall_q <= 1'b0;
      end else begin
         wr_q      <= wr_d;
         addr3_q   <= addr3_d;
         data3_q   <= data3_d;
         p_stall_q <= f_full;
      end
   end

   assign wr      = wr_q;
   assign addr3   = addr3_q;
   assign data3   = data3_q;
   assign p_stall = p_stall_q;

   // A pipeline write during a stall still wins, but it is a protocol slip.
   always @(posedge clk) begin
      if (reset)
         assert (!(p_stall_q && p_wr))
         else $error("pipeline write issued while p_stall is high");
   end

`ifdef REGFILE_WB_PENDING_EN
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_vld[i]) pending[ent_addr[i*AW +: AW]] = 1'b1;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based model of the write-port arbitration.
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          p_wr;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          p_stall;
   logic [CW-1:0] q_count;
   logic          wr;
   logic [AW-1:0] addr3;
   logic [DW-1:0] data3;
`ifdef REGFILE_WB_PENDING_EN
   logic [2**AW-1:0] pending;
`endif

   regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .p_wr    (p_wr),
      .p_addr  (p_addr),
      .p_data  (p_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_addr  (m_addr),
      .m_data  (m_data),
      .p_stall (p_stall),
      .q_count (q_count),
      .wr      (wr),
      .addr3   (addr3),
      .data3   (data3)
`ifdef REGFILE_WB_PENDING_EN
      ,
      .pending (pending)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   logic          exp_wr;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   logic          exp_stall;
   int            ncmp = 0;
   int            nfail = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_wr    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_stall = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wr"}, 64'(wr), 64'(exp_wr));
      chk({tag, ".addr3"}, 64'(addr3), 64'(exp_addr));
      chk({tag, ".data3"}, 64'(data3), 64'(exp_data));
      chk({tag, ".q_count"}, 64'(q_count), 64'(mq.size()));
      chk({tag, ".m_ready"}, 64'(m_ready), 64'(mq.size() != DEPTH));
      chk({tag, ".p_stall"}, 64'(p_stall), 64'(exp_stall));
`ifdef REGFILE_WB_PENDING_EN
      begin
         logic [2**AW-1:0] pm;
         pm = '0;
         foreach (mq[k]) pm[mq[k].a] = 1'b1;
         chk({tag, ".pending"}, 64'(pending), 64'(pm));
      end
`endif
   endtask

   // One clock: model decides from the inputs presented before the edge.
   task automatic step(input string tag);
      bit   take, hs;
      ent_t e;
      take = p_wr && (p_addr != 0);
      hs   = m_valid && (mq.size() != DEPTH);
      @(posedge clk);
      exp_stall = (mq.size() == DEPTH);
      if (take) begin
         exp_wr   = 1'b1;
         exp_addr = p_addr;
         exp_data = p_data;
      end else if (mq.size() > 0) begin
         e        = mq.pop_front();
         exp_wr   = 1'b1;
         exp_addr = e.a;
         exp_data = e.d;
      end else begin
         exp_wr = 1'b0;
      end
      if (hs && m_addr != 0) begin
         e.a = m_addr;
         e.d = m_data;
         mq.push_back(e);
      end
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      p_wr    = 1'b0;
      p_addr  = '0;
      p_data  = '0;
      m_valid = 1'b0;
      m_addr  = '0;
      m_data  = '0;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      model_reset();

      #12;
      chk("rst.wr", 64'(wr), 64'd0);
      chk("rst.addr3", 64'(addr3), 64'd0);
      chk("rst.data3", 64'(data3), 64'd0);
      chk("rst.q_count", 64'(q_count), 64'd0);
      chk("rst.p_stall", 64'(p_stall), 64'd0);
      chk("rst.m_ready", 64'(m_ready), 64'd0);
      #1 reset = 1'b1;
      #1 chk("rel.m_ready", 64'(m_ready), 64'd1);
      for (int i = 0; i < 3; i++) step("idle");

      p_wr   = 1'b1;
      p_addr = 5'd1;
      p_data = 32'h00ff00ff;
      step("pw");
      chk("pw.wr1", 64'(wr), 64'd1);
      chk("pw.data", 64'(data3), 64'h00ff00ff);
      idle();
      step("pw2");
      chk("pw.wr0", 64'(wr), 64'd0);

      m_valid = 1'b1;
      m_addr  = 5'd2;
      m_data  = 32'haa55aa55;
      step("qd0");
      chk("qd.nobypass", 64'(wr), 64'd0);
      idle();
      step("qd1");
      chk("qd.wr", 64'(wr), 64'd1);
      chk("qd.addr", 64'(addr3), 64'd2);
      chk("qd.data", 64'(data3), 64'haa55aa55);
      chk("qd.cnt", 64'(q_count), 64'd0);

      p_wr   = 1'b1;
      p_addr = 5'd3;
      for (int i = 0; i < 5; i++) begin
         p_data  = $urandom;
         m_valid = (i < 4);
         m_addr  = AW'(4 + i);
         m_data  = 32'h1000 + 32'(i);
         step("fill");
         chk("fill.addr", 64'(addr3), 64'd3);
      end
      chk("fill.cnt", 64'(q_count), 64'd4);
      chk("fill.mrdy", 64'(m_ready), 64'd0);
      chk("fill.stall", 64'(p_stall), 64'd1);
      idle();
      for (int i = 0; i < 4; i++) begin
         step("drain");
         chk("drain.addr", 64'(addr3), 64'(4 + i));
         chk("drain.data", 64'(data3), 64'h1000 + 64'(i));
      end
      step("drained");

      p_wr   = 1'b1;
      p_addr = 5'd0;
      p_data = 32'hdeadbeef;
      step("z.p");
      chk("z.pwr", 64'(wr), 64'd0);
      idle();
      m_valid = 1'b1;
      m_addr  = 5'd0;
      m_data  = 32'hcafef00d;
      #1 chk("z.hs", 64'(m_ready), 64'd1);
      step("z.m");
      idle();
      step("z.m2");
      chk("z.wr", 64'(wr), 64'd0);
      chk("z.cnt", 64'(q_count), 64'd0);

      p_wr   = 1'b1;
      p_addr = 5'd9;
      for (int i = 0; i < 3; i++) begin
         p_data  = $urandom;
         m_valid = 1'b1;
         m_addr  = AW'(10 + i);
         m_data  = $urandom;
         step("mr.fill");
      end
      chk("mr.cnt3", 64'(q_count), 64'd3);
      idle();
      reset = 1'b0;
      model_reset();
      #1;
      chk("mr.cnt", 64'(q_count), 64'd0);
      chk("mr.wr", 64'(wr), 64'd0);
      chk("mr.stall", 64'(p_stall), 64'd0);
`ifdef REGFILE_WB_PENDING_EN
      chk("mr.pend", 64'(pending), 64'd0);
`endif
      #3 reset = 1'b1;
      for (int i = 0; i < 4; i++) step("mr.post");

      for (int i = 0; i < 400; i++) begin
         p_wr    = !exp_stall && ($urandom_range(0, 9) < 4);
         p_addr  = AW'($urandom_range(0, 7));
         p_data  = $urandom;
         m_valid = ($urandom_range(0, 1) == 1);
         m_addr  = AW'($urandom_range(0, 7));
         m_data  = $urandom;
         step("rnd");
      end
      idle();
      for (int i = 0; i < DEPTH + 2; i++) step("tail");
      chk("tail.cnt", 64'(q_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
